// File: rtl/ecall_unit.sv
// Environment-call service unit: print/sleep/exit services for the single-cycle core,
// a PC/regfile stall while a service is pending, and an 8-digit seven-segment scan.
module ecall_unit #(
  parameter int SCAN_DIV  = 1024,
  parameter int SVC_PRINT = 34,
  parameter int SVC_SLEEP = 32,
  parameter int SVC_EXIT  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall,
  input  logic [31:0] a0_val,
  input  logic [31:0] a7_val,
  output logic        stall,
  output logic        halt,
  output logic [31:0] disp_value,
  output logic [15:0] ecall_count,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SLEEP  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int          PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  localparam logic [31:0] PRINT_CODE = 32'(SVC_PRINT);
  localparam logic [31:0] SLEEP_CODE = 32'(SVC_SLEEP);
  localparam logic [31:0] EXIT_CODE  = 32'(SVC_EXIT);

  logic [1:0]    state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   disp_q, disp_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;

  logic accept;
  logic is_print, is_sleep, is_exit;
  logic [3:0] nibble;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign accept   = ecall && (state_q == S_IDLE);
  assign is_print = (a7_val == PRINT_CODE);
  assign is_sleep = (a7_val == SLEEP_CODE);
  assign is_exit  = (a7_val == EXIT_CODE);

  assign stall = (state_q == S_SLEEP) || (state_q == S_HALTED) ||
                 (accept && is_exit) ||
                 (accept && is_sleep && (a0_val != 32'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (is_print) begin
            disp_d = a0_val;
          end else if (is_sleep) begin
            if (a0_val == 32'd1) begin
              state_d = S_DONE;
            end else if (a0_val != 32'd0) begin
              // Accept cycle is the first stalled cycle, so SLEEP covers the remaining N-1.
              cnt_d   = a0_val - 32'd1;
              state_d = S_SLEEP;
            end
          end else if (is_exit) begin
            state_d = S_HALTED;
          end
        end
      end
      S_SLEEP: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_HALTED;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      disp_q  <= 32'd0;
      count_q <= 16'd0;
      presc_q <= '0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      count_q <= count_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign halt        = (state_q == S_HALTED);
  assign disp_value  = disp_q;
  assign ecall_count = count_q;
  assign nibble      = disp_q[{idx_q, 2'b00} +: 4];
  assign seg_an      = ~(8'b0000_0001 << idx_q);
  assign seg_cat     = {~((idx_q == 3'd0) && halt), hex_to_seg(nibble)};

endmodule

// File: tb/tb_ecall_unit.sv
// Scoreboard-driven bench for ecall_unit: print, sleep lengths, reset mid-sleep,
// counter saturation and exit/halt with the display decimal point.
module tb_ecall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall;
  logic [31:0] a0_val;
  logic [31:0] a7_val;
  logic        stall;
  logic        halt;
  logic [31:0] disp_value;
  logic [15:0] ecall_count;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_disp_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [31:0] model_disp;
  logic [15:0] model_cnt;

  ecall_unit #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .ecall(ecall), .a0_val(a0_val), .a7_val(a7_val),
    .stall(stall), .halt(halt), .disp_value(disp_value), .ecall_count(ecall_count),
    .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: seg_of = 8'hC0; 4'h1: seg_of = 8'hF9; 4'h2: seg_of = 8'hA4; 4'h3: seg_of = 8'hB0;
      4'h4: seg_of = 8'h99; 4'h5: seg_of = 8'h92; 4'h6: seg_of = 8'h82; 4'h7: seg_of = 8'hF8;
      4'h8: seg_of = 8'h80; 4'h9: seg_of = 8'h90; 4'hA: seg_of = 8'h88; 4'hB: seg_of = 8'h83;
      4'hC: seg_of = 8'hC6; 4'hD: seg_of = 8'hA1; 4'hE: seg_of = 8'h86; default: seg_of = 8'h8E;
    endcase
  endfunction

  // Stimulus side of the scoreboard: record what an accepted ecall must produce.
  task automatic push_accept(input logic [31:0] a7, input logic [31:0] a0);
    if (a7 == 32'd34) model_disp = a0;
    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    exp_disp_q.push_back(model_disp);
    exp_cnt_q.push_back(model_cnt);
  endtask

  // Output side: pop and compare after the edge ending the accept cycle.
  task automatic pop_check(input string name);
    logic [31:0] ed;
    logic [15:0] ec;
    if (exp_disp_q.size() == 0 || exp_cnt_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    ed = exp_disp_q.pop_front();
    ec = exp_cnt_q.pop_front();
    total++;
    if (disp_value !== ed) begin
      bad++; $display("FAIL %s disp_value: got %h want %h", name, disp_value, ed);
    end
    total++;
    if (ecall_count !== ec) begin
      bad++; $display("FAIL %s ecall_count: got %h want %h", name, ecall_count, ec);
    end
  endtask

  task automatic check_digit(input string name, input logic [7:0] an, input logic [7:0] cat);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (seg_an === an) seen = 1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL %s: seg_an %h never seen, last %h", name, an, seg_an);
    end else if (seg_cat !== cat) begin
      bad++; $display("FAIL %s seg_cat: got %h want %h", name, seg_cat, cat);
    end
  endtask

  task automatic test_reset();
    rst = 1; ecall = 0; a0_val = 0; a7_val = 0;
    tick(); tick();
    rst = 0;
    model_disp = 0; model_cnt = 0;
    total++;
    if ({stall, halt} !== 2'b00) begin
      bad++; $display("FAIL reset stall/halt: got %b want 00", {stall, halt});
    end
    total++;
    if (disp_value !== 32'd0 || ecall_count !== 16'd0) begin
      bad++; $display("FAIL reset regs: got %h/%h want 0/0", disp_value, ecall_count);
    end
    total++;
    if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      bad++; $display("FAIL reset seg: got %h/%h want FE/C0", seg_an, seg_cat);
    end
  endtask

  task automatic test_print();
    ecall = 1; a7_val = 34; a0_val = 32'h1234ABCD;
    push_accept(a7_val, a0_val);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL print stall: got %b want 0", stall);
    end
    tick();
    ecall = 0;
    pop_check("print");
    check_digit("print idx0", 8'hFE, seg_of(4'hD));
    check_digit("print idx7", 8'h7F, seg_of(4'h1));
  endtask

  // Hold ecall through the whole service; drop it once the instruction retires.
  task automatic test_sleep(input logic [31:0] n);
    int stalls = 0;
    bit done = 0;
    ecall = 1; a7_val = 32; a0_val = n;
    push_accept(a7_val, a0_val);
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (stall === 1'b1) begin
        stalls++;
        tick();
      end else done = 1;
    end
    tick();
    ecall = 0;
    pop_check($sformatf("sleep%0d", n));
    total++;
    if (!done || stalls != int'(n)) begin
      bad++; $display("FAIL sleep%0d stall cycles: got %0d want %0d", n, stalls, n);
    end
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL sleep%0d idle stall: got %b want 0", n, stall);
    end
    tick();
  endtask

  task automatic test_reset_mid_sleep();
    ecall = 1; a7_val = 32; a0_val = 100;
    tick(); tick();
    rst = 1; ecall = 0;
    tick();
    rst = 0;
    model_disp = 0; model_cnt = 0;
    exp_disp_q.delete(); exp_cnt_q.delete();
    #1;
    total++;
    if ({stall, halt} !== 2'b00 || disp_value !== 32'd0 || ecall_count !== 16'd0) begin
      bad++; $display("FAIL midsleep reset: got stall=%b halt=%b disp=%h cnt=%h want 0", stall, halt, disp_value, ecall_count);
    end
    total++;
    if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      bad++; $display("FAIL midsleep seg: got %h/%h want FE/C0", seg_an, seg_cat);
    end
  endtask

  task automatic test_saturate();
    bit stalled = 0;
    ecall = 1; a7_val = 99; a0_val = 32'h5A5A5A5A;
    for (int i = 0; i < 65535; i++) begin
      push_accept(a7_val, a0_val);
      #1;
      if (stall !== 1'b0) stalled = 1;
      tick();
      void'(exp_disp_q.pop_front());
      void'(exp_cnt_q.pop_front());
    end
    total++;
    if (ecall_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat reach: got %h want FFFF", ecall_count);
    end
    push_accept(a7_val, a0_val);
    #1;
    if (stall !== 1'b0) stalled = 1;
    tick();
    ecall = 0;
    pop_check("sat extra");
    total++;
    if (stalled) begin
      bad++; $display("FAIL sat stall: got 1 want 0");
    end
  endtask

  task automatic test_exit();
    ecall = 1; a7_val = 34; a0_val = 32'h00000009;
    push_accept(a7_val, a0_val);
    tick();
    ecall = 0;
    pop_check("print9");
    tick();
    ecall = 1; a7_val = 10; a0_val = 0;
    push_accept(a7_val, a0_val);
    #1;
    total++;
    if (stall !== 1'b1 || halt !== 1'b0) begin
      bad++; $display("FAIL exit accept: got stall=%b halt=%b want 1/0", stall, halt);
    end
    tick();
    pop_check("exit");
    a7_val = 34; a0_val = 32'hDEADBEEF;
    #1;
    total++;
    if (stall !== 1'b1 || halt !== 1'b1) begin
      bad++; $display("FAIL halted: got stall=%b halt=%b want 1/1", stall, halt);
    end
    tick(); tick();
    total++;
    if (disp_value !== model_disp || ecall_count !== model_cnt) begin
      bad++; $display("FAIL halted ignore: got %h/%h want %h/%h", disp_value, ecall_count, model_disp, model_cnt);
    end
    check_digit("halt dp", 8'hFE, seg_of(4'h9) & 8'h7F);
    check_digit("halt idx1", 8'hFD, seg_of(4'h0));
    ecall = 0;
  endtask

  initial begin
    test_reset();
    test_print();
    test_sleep(32'd5);
    test_sleep(32'd0);
    test_sleep(32'd1);
    test_sleep(32'd2);
    test_reset_mid_sleep();
    test_saturate();
    test_exit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
